// File: rtl/nh_window_gather.sv
// Raster-stream to 2x2 stride-2 neighborhood gatherer. Buffers one image row and
// emits one packed window per pooling position through a valid/ready output slot.
module nh_window_gather #(
    parameter int unsigned NN_WIDTH   = 8,
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    localparam int unsigned NEIGHBORHOOD_SIZE = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NN_WIDTH-1:0]                   pix_in,
    input  logic                                  pix_valid,
    output logic                                  pix_ready,
    output logic [NEIGHBORHOOD_SIZE*NN_WIDTH-1:0] nh_out,
    output logic                                  nh_valid,
    input  logic                                  nh_ready,
    output logic                                  nh_last
);

    localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
    localparam logic [ColW-1:0] ColOne  = ColW'(1);
    localparam logic [RowW-1:0] RowOne  = RowW'(1);

    logic [ColW-1:0]                          col_q, col_d, col_left;
    logic [RowW-1:0]                          row_q, row_d;
    logic [NN_WIDTH-1:0]                      bl_q, bl_d;
    logic [NEIGHBORHOOD_SIZE*NN_WIDTH-1:0]    nh_out_q, nh_out_d;
    logic                                     nh_valid_q, nh_valid_d;
    logic                                     nh_last_q, nh_last_d;
    logic [NN_WIDTH-1:0]                      row_buf_q [IMG_WIDTH];
    logic                                     accept, win_done;

    assign pix_ready = !(nh_valid_q && !nh_ready);
    assign accept    = pix_valid && pix_ready;
    assign win_done  = accept && row_q[0] && col_q[0];
    // Window's left column is always the even neighbour of an odd col.
    assign col_left  = col_q & ~ColOne;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        bl_d       = bl_q;
        nh_out_d   = nh_out_q;
        nh_valid_d = nh_valid_q;
        nh_last_d  = nh_last_q;

        if (accept) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RowOne;
            end else begin
                col_d = col_q + ColOne;
            end
            if (row_q[0] && !col_q[0]) begin
                bl_d = pix_in;
            end
        end

        if (nh_valid_q && nh_ready) begin
            nh_valid_d = 1'b0;
            nh_last_d  = 1'b0;
        end

        // A new window on the consuming edge overrides the clear above.
        if (win_done) begin
            nh_out_d   = {pix_in, bl_q, row_buf_q[col_q], row_buf_q[col_left]};
            nh_valid_d = 1'b1;
            nh_last_d  = (row_q == RowLast) && (col_q == ColLast);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q      <= '0;
            row_q      <= '0;
            bl_q       <= '0;
            nh_out_q   <= '0;
            nh_valid_q <= 1'b0;
            nh_last_q  <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            bl_q       <= bl_d;
            nh_out_q   <= nh_out_d;
            nh_valid_q <= nh_valid_d;
            nh_last_q  <= nh_last_d;
        end
    end

    // Written only on even rows, read only on odd rows: no port conflict.
    always_ff @(posedge clock) begin
        if (accept && !row_q[0]) begin
            row_buf_q[col_q] <= pix_in;
        end
    end

    assign nh_out   = nh_out_q;
    assign nh_valid = nh_valid_q;
    assign nh_last  = nh_last_q;

endmodule

// File: tb/tb_nh_window_gather.sv
// Bench for nh_window_gather: a 4x4 instance for the small-frame scenarios and a
// default 28x28 instance, both checked every cycle against an image-array model.
module tb_nh_window_gather;

    typedef struct {
        int         br_idx;
        logic [7:0] tl, tr, bl, br;
        logic       last;
    } win_t;

    logic        clk, rst_n;
    logic        v4, r4, pr4, nv4, nl4;
    logic [7:0]  d4;
    logic [31:0] no4;
    logic        v28, r28, pr28, nv28, nl28;
    logic [7:0]  d28;
    logic [31:0] no28;

    int          checks, errors;
    win_t        tbl[4];
    logic [7:0]  src[$];
    logic [32:0] obs_log[$];

    // Reference model: full frame image plus one pending-window slot.
    logic [7:0]  img[28][28];
    int          m_n;
    logic        m_valid, m_last;
    logic [31:0] m_out;

    nh_window_gather #(.NN_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clock(clk), .reset(rst_n), .pix_in(d4), .pix_valid(v4), .pix_ready(pr4),
        .nh_out(no4), .nh_valid(nv4), .nh_ready(r4), .nh_last(nl4)
    );

    nh_window_gather dut28 (
        .clock(clk), .reset(rst_n), .pix_in(d28), .pix_valid(v28), .pix_ready(pr28),
        .nh_out(no28), .nh_valid(nv28), .nh_ready(r28), .nh_last(nl28)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_valid = 1'b0; m_last = 1'b0; m_out = '0;
    endtask

    task automatic cycle(input bit sel, input logic v, input logic [7:0] d, input logic rdy,
                         output logic acc);
        int w, r, c;
        logic exp_ready, pr, nv, nl;
        logic [31:0] no;
        w = sel ? 28 : 4;
        if (sel) begin
            v28 = v; d28 = d; r28 = rdy; v4 = 1'b0; r4 = 1'b1;
        end else begin
            v4 = v; d4 = d; r4 = rdy; v28 = 1'b0; r28 = 1'b1;
        end
        #1;
        pr = sel ? pr28 : pr4;
        nv = sel ? nv28 : nv4;
        nl = sel ? nl28 : nl4;
        no = sel ? no28 : no4;
        exp_ready = !(m_valid && !rdy);
        chk("pix_ready", pr, exp_ready);
        if (nv && rdy) obs_log.push_back({nl, no});
        acc = v && exp_ready;
        @(posedge clk);
        if (m_valid && rdy) begin
            m_valid = 1'b0; m_last = 1'b0;
        end
        if (acc) begin
            r = (m_n / w) % w;
            c = m_n % w;
            img[r][c] = d;
            if (r % 2 == 1 && c % 2 == 1) begin
                m_out   = {d, img[r][c-1], img[r-1][c], img[r-1][c-1]};
                m_valid = 1'b1;
                m_last  = (r == w - 1) && (c == w - 1);
            end
            m_n++;
        end
        #1;
        chk("nh_valid", sel ? nv28 : nv4, m_valid);
        chk("nh_last", sel ? nl28 : nl4, m_last);
        if (m_valid) chk("nh_out", sel ? no28 : no4, m_out);
    endtask

    // mode 0: continuous; 1: 5-cycle nh_ready stall after first window; 2: random gaps.
    task automatic stream(input bit sel, input int mode);
        int idx, guard, stall;
        logic v, rdy, acc;
        idx = 0; guard = 0; stall = -1;
        while (idx < src.size() && guard < src.size() * 4 + 50) begin
            v = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2)      rdy = ($urandom_range(0, 3) != 0);
            else if (mode == 1) rdy = !(stall > 0);
            else                rdy = 1'b1;
            cycle(sel, v, src[idx], rdy, acc);
            if (acc) idx++;
            if (mode == 1) begin
                if (stall < 0 && m_valid) stall = 5;
                else if (stall > 0) stall--;
            end
            guard++;
        end
        chk("stream_done", idx, src.size());
    endtask

    task automatic drain(input bit sel);
        logic acc;
        for (int i = 0; i < 10 && m_valid; i++) cycle(sel, 1'b0, 8'd0, 1'b1, acc);
        chk("drained", m_valid, 1'b0);
    endtask

    task automatic check_frame(input int base, input int off);
        logic [32:0] exp;
        if (obs_log.size() < base + 4) begin
            errors++;
            $display("FAIL frame_log: got %0d windows expected at least %0d",
                     obs_log.size(), base + 4);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            exp = {tbl[i].last, tbl[i].br + 8'(off), tbl[i].bl + 8'(off),
                   tbl[i].tr + 8'(off), tbl[i].tl + 8'(off)};
            chk($sformatf("frame_win%0d", base + i), obs_log[base + i], exp);
        end
    endtask

    task automatic do_reset();
        v4 = 1'b0; v28 = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_pix_ready", pr4, 1'b1);
        chk("rst_nh_valid", nv4, 1'b0);
        chk("rst_nh_last", nl4, 1'b0);
        chk("rst_nh_out", no4, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_ramp(input int base, input int n);
        for (int i = 0; i < n; i++) src.push_back(8'((base + i) % 256));
    endtask

    initial begin
        int nlast, b, f, wi;
        logic [32:0] exp;
        checks = 0; errors = 0;
        clk = 1'b0; rst_n = 1'b0;
        v4 = 0; d4 = 0; r4 = 1; v28 = 0; d28 = 0; r28 = 1;
        model_reset();
        tbl[0] = '{5,  8'd0,  8'd1,  8'd4,  8'd5,  1'b0};
        tbl[1] = '{7,  8'd2,  8'd3,  8'd6,  8'd7,  1'b0};
        tbl[2] = '{13, 8'd8,  8'd9,  8'd12, 8'd13, 1'b0};
        tbl[3] = '{15, 8'd10, 8'd11, 8'd14, 8'd15, 1'b1};

        #12;
        chk("rst_pix_ready", pr4, 1'b1);
        chk("rst_nh_valid", nv4, 1'b0);
        chk("rst_nh_out", no4, 32'd0);
        chk("rst28_pix_ready", pr28, 1'b1);
        chk("rst28_nh_valid", nv28, 1'b0);
        chk("rst28_nh_last", nl28, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous 4x4 frame.
        src.delete(); load_ramp(0, 16); obs_log.delete();
        stream(0, 0); drain(0);
        chk("s1_count", obs_log.size(), 4);
        check_frame(0, 0);

        // Downstream stall after the first window.
        src.delete(); load_ramp(0, 16); obs_log.delete();
        stream(0, 1); drain(0);
        chk("s2_count", obs_log.size(), 4);
        check_frame(0, 0);

        // Random data, random valid gaps and backpressure, two frames.
        src.delete();
        for (int i = 0; i < 32; i++) src.push_back(8'($urandom_range(0, 255)));
        obs_log.delete();
        stream(0, 2); drain(0);
        chk("s3_count", obs_log.size(), 8);
        if (obs_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                f = k / 4; wi = k % 4;
                b = f * 16 + (wi / 2) * 8 + (wi % 2) * 2;
                exp = {1'(wi == 3), src[b + 5], src[b + 4], src[b + 1], src[b]};
                chk($sformatf("s3_win%0d", k), obs_log[k], exp);
            end
        end

        // Back-to-back frames.
        src.delete(); load_ramp(0, 16); load_ramp(100, 16); obs_log.delete();
        stream(0, 0); drain(0);
        chk("s4_count", obs_log.size(), 8);
        check_frame(0, 0);
        check_frame(4, 100);

        // Reset mid-frame, then a clean frame.
        src.delete(); load_ramp(0, 10);
        stream(0, 0);
        do_reset();
        src.delete(); load_ramp(0, 16); obs_log.delete();
        stream(0, 0); drain(0);
        chk("s5_count", obs_log.size(), 4);
        check_frame(0, 0);

        // Default 28x28 frame.
        model_reset();
        src.delete(); load_ramp(0, 784); obs_log.delete();
        stream(1, 0); drain(1);
        chk("s6_count", obs_log.size(), 196);
        if (obs_log.size() == 196) begin
            chk("s6_first", obs_log[0], {1'b0, 8'd29, 8'd28, 8'd1, 8'd0});
            chk("s6_final_last", obs_log[195][32], 1'b1);
            nlast = 0;
            foreach (obs_log[i]) if (obs_log[i][32]) nlast++;
            chk("s6_last_count", nlast, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
